// File: rtl/interval_timer.sv
`timescale 1ns/1ps
// Multi-channel programmable interval timer sharing one tick prescaler.
// Each channel counts prescaled ticks up to its period and emits a one-cycle done pulse.
module interval_timer #(
  parameter int WORD_LENGTH = 16,
  parameter int CHANNELS    = 4,
  parameter int PRESCALE    = 100,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [CHANNELS-1:0]    enable_i,
  input  logic [CHANNELS-1:0]    periodic_i,
  input  logic                   load_i,
  input  logic [CH_W-1:0]        load_channel_i,
  input  logic [WORD_LENGTH-1:0] period_i,
  output logic [CHANNELS-1:0]    done_o,
  output logic [CHANNELS-1:0]    busy_o
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  logic [PS_W-1:0]        prescaler;
  logic                   tick;
  state_t                 state      [CHANNELS];
  state_t                 state_next [CHANNELS];
  logic [WORD_LENGTH-1:0] count      [CHANNELS];
  logic [WORD_LENGTH-1:0] count_next [CHANNELS];
  logic [WORD_LENGTH-1:0] period     [CHANNELS];
  logic [CHANNELS-1:0]    terminal;
  logic [CHANNELS-1:0]    done_next;
  logic [CHANNELS-1:0]    busy_next;

  // With PRESCALE=1 the counter is stuck at 0 == PS_LAST, so tick is constant high.
  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < CHANNELS; c++) period[c] <= '0;
    end else if (load_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (32'(load_channel_i) == c) period[c] <= period_i;
      end
    end
  end

  // count+1 >= period in one extra bit: same as count >= period-1 but without
  // wrapping, so a zero period loaded mid-run simply fires on every tick.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      terminal[c] = ({1'b0, count[c]} + (WORD_LENGTH + 1)'(1)) >= {1'b0, period[c]};
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_next[c] = state[c];
      count_next[c] = count[c];
      done_next[c]  = 1'b0;
      busy_next[c]  = 1'b0;
      if (!enable_i[c]) begin
        state_next[c] = IDLE;
        count_next[c] = '0;
      end else begin
        case (state[c])
          IDLE: begin
            count_next[c] = '0;
            if (period[c] != '0) state_next[c] = RUN;
          end
          RUN: begin
            if (tick) begin
              if (terminal[c]) begin
                count_next[c] = '0;
                done_next[c]  = 1'b1;
                state_next[c] = periodic_i[c] ? RUN : EXPIRED;
              end else begin
                count_next[c] = count[c] + WORD_LENGTH'(1);
              end
            end
          end
          EXPIRED: begin
            count_next[c] = '0;
          end
          default: begin
            state_next[c] = IDLE;
            count_next[c] = '0;
          end
        endcase
      end
      busy_next[c] = (state_next[c] == RUN);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state[c] <= IDLE;
        count[c] <= '0;
      end
      done_o <= '0;
      busy_o <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state[c] <= state_next[c];
        count[c] <= count_next[c];
      end
      done_o <= done_next;
      busy_o <= busy_next;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
`timescale 1ns/1ps
// Bench for interval_timer: expected done pulses are queued as stimulus is driven
// and drained by a monitor that samples done_o on the falling edge.
module tb_interval_timer;

  localparam int WL = 16;
  localparam int CH = 4;
  localparam int PS = 4;

  typedef struct {
    int ch;
    int at;
  } pulse_t;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [CH-1:0] enable_i = '0;
  logic [CH-1:0] periodic_i = '0;
  logic          load_i = 1'b0;
  logic [1:0]    load_channel_i = '0;
  logic [WL-1:0] period_i = '0;
  logic [CH-1:0] done_o;
  logic [CH-1:0] busy_o;

  logic [2:0]    enable3 = '0;
  logic          load3 = 1'b0;
  logic [1:0]    load_ch3 = '0;
  logic [WL-1:0] period3 = '0;
  logic [2:0]    done3;
  logic [2:0]    busy3;

  pulse_t exp_q[$];
  pulse_t mon_e;
  int     checks = 0;
  int     errors = 0;
  int     edge_n = 0;
  int     pulse_count [CH];
  int     t_shrink;

  interval_timer #(.WORD_LENGTH(WL), .CHANNELS(CH), .PRESCALE(PS)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .periodic_i(periodic_i),
    .load_i(load_i), .load_channel_i(load_channel_i), .period_i(period_i),
    .done_o(done_o), .busy_o(busy_o)
  );

  interval_timer #(.WORD_LENGTH(WL), .CHANNELS(3), .PRESCALE(PS)) dut3 (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable3), .periodic_i(3'b111),
    .load_i(load3), .load_channel_i(load_ch3), .period_i(period3),
    .done_o(done3), .busy_o(busy3)
  );

  always #5 clock_i = ~clock_i;

  // edge_n counts rising edges since reset release; ticks fall on multiples of PS.
  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) edge_n <= 0;
    else edge_n <= edge_n + 1;
  end

  always @(negedge clock_i) begin
    if (!reset_i) begin
      while (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_pulse ch%0d: no pulse seen, required at edge %0d", exp_q[0].ch, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      for (int c = 0; c < CH; c++) begin
        if (done_o[c] === 1'b1) begin
          pulse_count[c]++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pulse ch%0d: pulse at edge %0d, required none", c, edge_n);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.ch != c || mon_e.at != edge_n) begin
              errors++;
              $display("[TB] FAIL pulse_timing: got ch%0d at edge %0d, required ch%0d at edge %0d",
                       c, edge_n, mon_e.ch, mon_e.at);
            end
          end
        end
      end
    end
  end

  function automatic int first_done(int e0, int p);
    return ((e0 / PS) + 1) * PS + (p - 1) * PS;
  endfunction

  task automatic step();
    @(posedge clock_i);
    #2;
  endtask

  task automatic wait_until(int n);
    while (edge_n < n) step();
  endtask

  task automatic push_pulse(int ch, int at);
    pulse_t p;
    p.ch = ch;
    p.at = at;
    exp_q.push_back(p);
  endtask

  task automatic load(int ch, int p);
    load_i = 1'b1;
    load_channel_i = 2'(ch);
    period_i = WL'(p);
    step();
    load_i = 1'b0;
  endtask

  task automatic check_busy(string name, logic [CH-1:0] required);
    checks++;
    if (busy_o !== required) begin
      errors++;
      $display("[TB] FAIL %s: busy_o=%b required %b", name, busy_o, required);
    end
  endtask

  task automatic check_count(string name, int ch, int base, int required);
    checks++;
    if (pulse_count[ch] - base !== required) begin
      errors++;
      $display("[TB] FAIL %s: ch%0d pulses=%0d required %0d", name, ch, pulse_count[ch] - base, required);
    end
  endtask

  task automatic check_drained(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d pulses still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock_i);
    #2;
    checks++;
    if (done_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_done: done_o=%b required 0000", done_o);
    end
    check_busy("reset_busy", 4'b0000);
    reset_i = 1'b0;
    step();
    check_busy("post_reset_busy", 4'b0000);
  endtask

  task automatic test_periodic();
    int e0, d;
    load(0, 3);
    periodic_i[0] = 1'b1;
    enable_i[0] = 1'b1;
    e0 = edge_n + 1;
    d = first_done(e0, 3);
    for (int k = 0; k < 5; k++) push_pulse(0, d + 12 * k);
    step();
    while (edge_n < d + 48) begin
      check_busy("periodic_busy", 4'b0001);
      step();
    end
    enable_i[0] = 1'b0;
    step();
    step();
    check_busy("periodic_stop_busy", 4'b0000);
    check_drained("periodic_drained");
  endtask

  task automatic test_one_shot();
    int e0, d, base;
    base = pulse_count[1];
    load(1, 2);
    periodic_i[1] = 1'b0;
    enable_i[1] = 1'b1;
    e0 = edge_n + 1;
    d = first_done(e0, 2);
    push_pulse(1, d);
    step();
    check_busy("one_shot_busy", 4'b0010);
    wait_until(d);
    check_busy("one_shot_expired", 4'b0000);
    wait_until(d + 100);
    check_count("one_shot_single", 1, base, 1);
    check_busy("one_shot_idle", 4'b0000);
    enable_i[1] = 1'b0;
    step();
    enable_i[1] = 1'b1;
    e0 = edge_n + 1;
    d = first_done(e0, 2);
    push_pulse(1, d);
    step();
    check_busy("rearm_busy", 4'b0010);
    wait_until(d + 20);
    check_count("rearm_pulse", 1, base, 2);
    check_busy("rearm_expired", 4'b0000);
    enable_i[1] = 1'b0;
    step();
    check_drained("one_shot_drained");
  endtask

  task automatic test_zero_period();
    int e0, d, base;
    base = pulse_count[2];
    periodic_i[2] = 1'b1;
    enable_i[2] = 1'b1;
    wait_until(edge_n + 100);
    check_busy("zero_period_busy", 4'b0000);
    check_count("zero_period_pulses", 2, base, 0);
    load(2, 1);
    e0 = edge_n + 1;
    d = first_done(e0, 1);
    for (int k = 0; k < 5; k++) push_pulse(2, d + 4 * k);
    step();
    check_busy("period_one_busy", 4'b0100);
    wait_until(d + 16);
    enable_i[2] = 1'b0;
    step();
    step();
    check_busy("period_one_stop", 4'b0000);
    check_drained("period_one_drained");
  endtask

  task automatic test_period_shrink();
    int e0;
    load(0, 10);
    periodic_i[0] = 1'b1;
    enable_i[0] = 1'b1;
    e0 = edge_n + 1;
    t_shrink = ((e0 / PS) + 1) * PS;
    // Count reaches 6 on the sixth tick; the shrunk period fires on the next tick.
    wait_until(t_shrink + 20);
    load(0, 5);
    push_pulse(0, t_shrink + 24);
    push_pulse(0, t_shrink + 44);
    push_pulse(0, t_shrink + 64);
    wait_until(t_shrink + 65);
    check_busy("shrink_busy", 4'b0001);
    check_drained("shrink_drained");
  endtask

  task automatic test_enable_drop();
    int e0, d, base;
    wait_until(t_shrink + 83);
    base = pulse_count[0];
    enable_i[0] = 1'b0;
    step();
    enable_i[0] = 1'b1;
    e0 = edge_n + 1;
    d = first_done(e0, 5);
    push_pulse(0, d);
    wait_until(t_shrink + 90);
    check_count("drop_no_pulse", 0, base, 0);
    wait_until(d + 2);
    check_count("reenable_pulse", 0, base, 1);
    check_busy("reenable_busy", 4'b0001);
    enable_i[0] = 1'b0;
    step();
    step();
    check_drained("enable_drop_drained");
  endtask

  task automatic test_out_of_range();
    load3 = 1'b1;
    load_ch3 = 2'd3;
    period3 = 16'd5;
    step();
    load3 = 1'b0;
    enable3 = 3'b111;
    repeat (3) step();
    checks++;
    if (busy3 !== 3'b000 || done3 !== 3'b000) begin
      errors++;
      $display("[TB] FAIL out_of_range_load: busy=%b done=%b required 000 000", busy3, done3);
    end
    load3 = 1'b1;
    load_ch3 = 2'd2;
    period3 = 16'd2;
    step();
    load3 = 1'b0;
    step();
    checks++;
    if (busy3 !== 3'b100) begin
      errors++;
      $display("[TB] FAIL in_range_load: busy=%b required 100", busy3);
    end
    enable3 = 3'b000;
    step();
  endtask

  task automatic test_async_reset();
    int e0, d, total;
    load(3, 3);
    periodic_i[3] = 1'b1;
    enable_i[3] = 1'b1;
    e0 = edge_n + 1;
    d = first_done(e0, 3);
    push_pulse(3, d);
    wait_until(d);
    #1;
    checks++;
    if (done_o !== 4'b1000 || busy_o !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL pre_reset: done=%b busy=%b required 1000 1000", done_o, busy_o);
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if (done_o !== 4'b0000 || busy_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset: done=%b busy=%b required 0000 0000", done_o, busy_o);
    end
    exp_q.delete();
    repeat (2) @(posedge clock_i);
    #3;
    reset_i = 1'b0;
    total = pulse_count[0] + pulse_count[1] + pulse_count[2] + pulse_count[3];
    periodic_i = '1;
    enable_i = '1;
    wait_until(100);
    check_busy("cleared_period_busy", 4'b0000);
    checks++;
    if (pulse_count[0] + pulse_count[1] + pulse_count[2] + pulse_count[3] !== total) begin
      errors++;
      $display("[TB] FAIL cleared_period_pulses: got %0d new pulses, required 0",
               pulse_count[0] + pulse_count[1] + pulse_count[2] + pulse_count[3] - total);
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) pulse_count[c] = 0;
    test_reset();
    test_periodic();
    test_one_shot();
    test_zero_period();
    test_period_shrink();
    test_enable_drop();
    test_out_of_range();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
